// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage 16-bit
// datapath. Holds the PC, presents it to instruction memory, and captures the
// fetched word together with PC+PC_INC into IF/ID. Control requests from ID
// are applied once per rising edge, in this order of precedence:
//    HLT freeze > stall > jump > taken branch > normal fetch.
//
// Ports:
//    clk, rst        rising-edge clock, asynchronous active-high reset
//    instr_addr      instruction-memory address (= pc, combinational)
//    instr_data      combinational read data for instr_addr
//    stall           hold pc and IF/ID
//    brnch_taken     redirect to brnch_target (bit0 forced to 0)
//    brnch_target
//    jmp             redirect to jmp_target (bit0 forced to 0), beats branch
//    jmp_target
//    if_id_clr       HLT decoded: flush IF/ID and freeze until reset
//    if_id_instr     IF/ID instruction (NOP_INSTR when bubble)
//    if_id_pc2       PC+PC_INC of the instruction in IF/ID
//    if_id_valid     IF/ID holds a real instruction (not a bubble)
//    opcode          if_id_instr[15:12], combinational slice
//    func_code       if_id_instr[3:0], combinational slice
//    halted          front end frozen by HLT; decodes the FSM state register
//    fetch_count     saturating count of real instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int unsigned           PC_W      = 16,
   parameter int unsigned           INSTR_W   = 16,
   parameter logic [PC_W-1:0]       RESET_PC  = 16'h0000,
   parameter logic [INSTR_W-1:0]    NOP_INSTR = 16'h7000,
   parameter int unsigned           PC_INC    = 2
) (
   input  logic                clk,
   input  logic                rst,
   output logic [PC_W-1:0]     instr_addr,
   input  logic [INSTR_W-1:0]  instr_data,
   input  logic                stall,
   input  logic                brnch_taken,
   input  logic [PC_W-1:0]     brnch_target,
   input  logic                jmp,
   input  logic [PC_W-1:0]     jmp_target,
   input  logic                if_id_clr,
   output logic [INSTR_W-1:0]  if_id_instr,
   output logic [PC_W-1:0]     if_id_pc2,
   output logic                if_id_valid,
   output logic [3:0]          opcode,
   output logic [3:0]          func_code,
   output logic                halted,
   output logic [15:0]         fetch_count
);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   // Instructions are halfword aligned; a target's bit0 is dropped so a
   // mis-formed target can never produce an odd fetch address.
   localparam logic [PC_W-1:0] ALIGN_MASK = ~{{(PC_W-1){1'b0}}, 1'b1};

   state_t               state_q,         state_d;
   logic [PC_W-1:0]      pc_q,            pc_d;
   logic [INSTR_W-1:0]   if_id_instr_q,   if_id_instr_d;
   logic [PC_W-1:0]      if_id_pc2_q,     if_id_pc2_d;
   logic                 if_id_valid_q,   if_id_valid_d;
   logic [15:0]          fetch_count_q,   fetch_count_d;

   logic [PC_W-1:0]      pc_next_seq;

   // Wraps modulo 2^PC_W: 16'hFFFE + 2 = 16'h0000.
   assign pc_next_seq = pc_q + PC_W'(PC_INC);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_pc2_d   = if_id_pc2_q;
      if_id_valid_d = if_id_valid_q;
      fetch_count_d = fetch_count_q;

      case (state_q)
         ST_RUN: begin
            if (if_id_clr) begin
               if_id_instr_d = NOP_INSTR;
               if_id_valid_d = 1'b0;
               state_d       = ST_HALTED;
            end else if (stall) begin
               // A stalled ID branch may be using stale operands; it will
               // re-assert once the stall clears, so the redirect waits.
            end else if (jmp) begin
               pc_d          = jmp_target & ALIGN_MASK;
               if_id_instr_d = NOP_INSTR;
               if_id_valid_d = 1'b0;
            end else if (brnch_taken) begin
               pc_d          = brnch_target & ALIGN_MASK;
               if_id_instr_d = NOP_INSTR;
               if_id_valid_d = 1'b0;
            end else begin
               if_id_instr_d = instr_data;
               if_id_pc2_d   = pc_next_seq;
               if_id_valid_d = 1'b1;
               pc_d          = pc_next_seq;
               if (fetch_count_q != 16'hFFFF) begin
                  fetch_count_d = fetch_count_q + 16'd1;
               end
            end
         end
         ST_HALTED: begin
            // Everything frozen; only rst leaves this state.
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         if_id_instr_q <= NOP_INSTR;
         if_id_pc2_q   <= '0;
         if_id_valid_q <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_pc2_q   <= if_id_pc2_d;
         if_id_valid_q <= if_id_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign instr_addr  = pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_pc2   = if_id_pc2_q;
   assign if_id_valid = if_id_valid_q;
   assign opcode      = if_id_instr_q[INSTR_W-1 -: 4];
   assign func_code   = if_id_instr_q[3:0];
   assign halted      = (state_q == ST_HALTED);
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage. Instruction memory is a combinational
// function of the address so every fetched word is predictable. Inputs are
// changed 1ns after a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

   localparam logic [15:0] NOP = 16'h7000;

   logic        clk;
   logic        rst;
   logic [15:0] instr_addr;
   logic [15:0] instr_data;
   logic        stall;
   logic        brnch_taken;
   logic [15:0] brnch_target;
   logic        jmp;
   logic [15:0] jmp_target;
   logic        if_id_clr;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc2;
   logic        if_id_valid;
   logic [3:0]  opcode;
   logic [3:0]  func_code;
   logic        halted;
   logic [15:0] fetch_count;

   int checks_done;
   int errors_seen;

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- dut
   if_fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .instr_addr   (instr_addr),
      .instr_data   (instr_data),
      .stall        (stall),
      .brnch_taken  (brnch_taken),
      .brnch_target (brnch_target),
      .jmp          (jmp),
      .jmp_target   (jmp_target),
      .if_id_clr    (if_id_clr),
      .if_id_instr  (if_id_instr),
      .if_id_pc2    (if_id_pc2),
      .if_id_valid  (if_id_valid),
      .opcode       (opcode),
      .func_code    (func_code),
      .halted       (halted),
      .fetch_count  (fetch_count)
   );

   // Address-dependent memory contents.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return (a * 16'd3) ^ 16'h5A5A;
   endfunction

   assign instr_data = mem_word(instr_addr);

   // ---------------------------------------------------------------- helpers
   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks_done++;
      if (obs !== exp) begin
         errors_seen++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      stall        = 1'b0;
      brnch_taken  = 1'b0;
      brnch_target = 16'h0000;
      jmp          = 1'b0;
      jmp_target   = 16'h0000;
      if_id_clr    = 1'b0;
   endtask

   task automatic check_if_id(input string tag, input logic [15:0] exp_pc,
                              input logic [15:0] exp_instr,
                              input logic [15:0] exp_pc2,
                              input logic exp_valid,
                              input logic [15:0] exp_fc);
      logic [15:0] w;
      w = exp_instr;
      check_eq({tag, "_pc"},    instr_addr,  exp_pc);
      check_eq({tag, "_instr"}, if_id_instr, exp_instr);
      check_eq({tag, "_pc2"},   if_id_pc2,   exp_pc2);
      check_eq({tag, "_valid"}, if_id_valid, exp_valid);
      check_eq({tag, "_fc"},    fetch_count, exp_fc);
      check_eq({tag, "_opc"},   opcode,      w[15:12]);
      check_eq({tag, "_func"},  func_code,   w[3:0]);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      checks_done = 0;
      errors_seen = 0;
      rst = 1'b1;
      drive_idle();
      #1;
      // Reset values.
      check_if_id("rst", 16'h0000, NOP, 16'h0000, 1'b0, 16'd0);
      check_eq("rst_halted", halted, 1'b0);
      step();
      step();
      rst = 1'b0;

      // Free run: pc 2,4,6 after three loads.
      step();
      check_if_id("run1", 16'h0002, mem_word(16'h0000), 16'h0002, 1'b1, 16'd1);
      step();
      check_if_id("run2", 16'h0004, mem_word(16'h0002), 16'h0004, 1'b1, 16'd2);
      step();
      check_if_id("run3", 16'h0006, mem_word(16'h0004), 16'h0006, 1'b1, 16'd3);

      // Stall two cycles at pc=6.
      stall = 1'b1;
      step();
      check_if_id("stall1", 16'h0006, mem_word(16'h0004), 16'h0006, 1'b1, 16'd3);
      step();
      check_if_id("stall2", 16'h0006, mem_word(16'h0004), 16'h0006, 1'b1, 16'd3);
      stall = 1'b0;
      step();
      check_if_id("resume", 16'h0008, mem_word(16'h0006), 16'h0008, 1'b1, 16'd4);
      step();
      check_if_id("run5", 16'h000A, mem_word(16'h0008), 16'h000A, 1'b1, 16'd5);

      // Taken branch at pc=10 to odd target 0x41 -> 0x40, one bubble.
      brnch_taken  = 1'b1;
      brnch_target = 16'h0041;
      step();
      check_if_id("br_bubble", 16'h0040, NOP, 16'h000A, 1'b0, 16'd5);
      drive_idle();
      step();
      check_if_id("br_target", 16'h0042, mem_word(16'h0040), 16'h0042, 1'b1, 16'd6);

      // jmp + branch + stall together: stall wins, then jmp beats branch.
      jmp          = 1'b1;
      jmp_target   = 16'h0020;
      brnch_taken  = 1'b1;
      brnch_target = 16'h0080;
      stall        = 1'b1;
      step();
      check_if_id("all_stall", 16'h0042, mem_word(16'h0040), 16'h0042, 1'b1, 16'd6);
      stall = 1'b0;
      step();
      check_if_id("jmp_wins", 16'h0020, NOP, 16'h0042, 1'b0, 16'd6);

      // Jump to 0x13 (-> 0x12), then HLT there.
      brnch_taken = 1'b0;
      jmp_target  = 16'h0013;
      step();
      check_eq("jmp_odd_pc", instr_addr, 16'h0012);
      drive_idle();
      if_id_clr = 1'b1;
      step();
      check_if_id("hlt", 16'h0012, NOP, 16'h0042, 1'b0, 16'd6);
      check_eq("hlt_halted", halted, 1'b1);
      if_id_clr = 1'b0;
      for (int i = 0; i < 10; i++) begin
         jmp          = i[0];
         jmp_target   = 16'h0100;
         stall        = i[1];
         brnch_taken  = i[2];
         brnch_target = 16'h0200;
         step();
         check_eq("halt_pc",     instr_addr,  16'h0012);
         check_eq("halt_instr",  if_id_instr, NOP);
         check_eq("halt_valid",  if_id_valid, 1'b0);
         check_eq("halt_fc",     fetch_count, 16'd6);
         check_eq("halt_halted", halted,      1'b1);
      end

      // Reset while halted takes effect without a clock edge.
      rst = 1'b1;
      #1;
      check_if_id("rst_halt", 16'h0000, NOP, 16'h0000, 1'b0, 16'd0);
      check_eq("rst_halt_halted", halted, 1'b0);
      drive_idle();
      step();
      rst = 1'b0;
      step();
      check_if_id("post_rst", 16'h0002, mem_word(16'h0000), 16'h0002, 1'b1, 16'd1);

      // PC wrap from 0xFFFE.
      jmp        = 1'b1;
      jmp_target = 16'hFFFE;
      step();
      check_if_id("wrap_jmp", 16'hFFFE, NOP, 16'h0002, 1'b0, 16'd1);
      drive_idle();
      step();
      check_if_id("wrap", 16'h0000, mem_word(16'hFFFE), 16'h0000, 1'b1, 16'd2);

      // Async reset between edges.
      #2;
      rst = 1'b1;
      #1;
      check_if_id("async_rst", 16'h0000, NOP, 16'h0000, 1'b0, 16'd0);
      check_eq("async_rst_halted", halted, 1'b0);
      #2;
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks_done, errors_seen);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage 16-bit datapath. Holds the PC, drives the instruction-memory address, and registers the fetched word plus PC+2 into IF/ID. The ID stage's decoder consumes if_id_instr[15:12] (opcode) and [3:0] (function code). The block applies stall, branch/jump redirect, flush, and the HLT freeze requested by the ID-stage control signals.

Parameters:
PC_W, 16, PC and address width
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value after reset
NOP_INSTR, 16'h7000, bubble encoding; opcode 0111 decodes to all-zero controls
PC_INC, 2, byte increment per instruction

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_addr  out  PC_W  instruction-memory address; equals pc
instr_data  in  INSTR_W  combinational instruction-memory read data for instr_addr
stall  in  1  hazard unit: hold PC and IF/ID
brnch_taken  in  1  ID: branch condition resolved true
brnch_target  in  PC_W  ID: branch target address
jmp  in  1  ID: unconditional jump
jmp_target  in  PC_W  ID: jump target address
if_id_clr  in  1  ID: HLT decoded; freeze the front end
if_id_instr  out  INSTR_W  IF/ID instruction
if_id_pc2  out  PC_W  IF/ID PC+PC_INC of that instruction
if_id_valid  out  1  IF/ID holds a real, non-bubble instruction
opcode  out  4  if_id_instr[15:12]
func_code  out  4  if_id_instr[3:0]
halted  out  1  front end frozen by HLT
fetch_count  out  16  count of real instructions loaded into IF/ID, saturating

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc2=0, if_id_valid=0, halted=0, fetch_count=0, FSM=RUN.
- FSM states RUN and HALTED. RUN->HALTED on a clock edge with if_id_clr=1. HALTED exits only on rst.
- Per-edge priority in RUN, highest first:
  1. if_id_clr: pc held; IF/ID <= NOP_INSTR, valid=0; go to HALTED.
  2. stall: pc and IF/ID held unchanged. Stall dominates redirect, because a stalled ID branch may have stale operands and re-asserts next cycle.
  3. jmp: pc <= {jmp_target[PC_W-1:1],1'b0}; IF/ID <= NOP_INSTR, valid=0 (wrong-path flush). jmp beats brnch_taken if both are asserted.
  4. brnch_taken: as jmp, using brnch_target.
  5. Normal: IF/ID <= instr_data, if_id_pc2 <= pc+PC_INC, valid=1; pc <= pc+PC_INC.
- PC arithmetic is modulo 2^PC_W: 16'hFFFE + 2 = 16'h0000. Target bit0 is forced to 0.
- Redirect penalty is exactly 1 bubble: a taken branch in ID at edge N gives the target instruction in IF/ID at edge N+1.
- HALTED: pc, IF/ID (NOP), and fetch_count frozen. All inputs except rst are ignored. halted=1 from the edge that sampled if_id_clr.
- fetch_count increments only on normal loads (case 5) and saturates at 16'hFFFF.
- opcode and func_code are purely combinational slices of if_id_instr; no extra latency.
- All outputs are registered except instr_addr, opcode, and func_code.

Test Plan:
- Reset then free run, memory returns addr-dependent words: PC 0,2,4,6 on successive cycles; if_id_pc2=2 with word@0 one cycle after reset; fetch_count=3 after 3 loads.
- Stall 2 cycles at pc=6: pc stays 6 and IF/ID holds word@4 for both cycles; fetch resumes at 6 after stall drops; fetch_count does not advance during the stall.
- brnch_taken with brnch_target=16'h0041 at pc=10: next cycle IF/ID=16'h7000, valid=0, pc=16'h0040; the following cycle IF/ID=word@0x40.
- jmp=1 (target 0x20), brnch_taken=1 (target 0x80), and stall=1 together: nothing changes. Drop stall: pc=0x20 (jmp wins).
- if_id_clr pulse at pc=0x12: halted=1, IF/ID=NOP, pc frozen at 0x12 for 10 cycles despite jmp/stall toggling. rst mid-halt restores pc=0, halted=0.
- pc preset to 0xFFFE via jmp: next normal fetch gives pc=0x0000, if_id_pc2=0x0000. Async rst asserted between edges: outputs reset immediately, without waiting for a clock edge.
